// File: rtl/tiny_ifft.sv
// tiny_ifft: 4-point inverse transform on 4-bit serial bins using the 8-bit io_in/io_out tile packaging.
// Optional round-half-up scaling is enabled with the IFFT_ROUND_EN macro; the default scaling is floor.
module tiny_ifft (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    typedef enum logic [0:0] {HUNT = 1'b0, COLLECT = 1'b1} state_t;

    logic       w_clk;
    logic       w_rst;
    logic       w_sof_in;
    logic       w_in_valid;
    logic [3:0] w_bin_in;
    logic       w_last;
    logic [3:0] w_y0, w_y1, w_y2, w_y3;

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_x0, r_x1, r_x2;
    logic [3:0] r_y1, r_y2, r_y3;
    logic [1:0] r_emit_cnt;
    logic [3:0] r_sample;
    logic       r_sof;
    logic       r_valid;
    logic       r_err;

    assign w_clk      = io_in[0];
    assign w_rst      = io_in[1];
    assign w_sof_in   = io_in[2];
    assign w_in_valid = io_in[3];
    assign w_bin_in   = io_in[7:4];
    assign io_out     = {r_sample, 1'b0, r_err, r_valid, r_sof};

    function automatic logic [5:0] sext(input logic [3:0] b);
        return {{2{b[3]}}, b};
    endfunction

    // Bits [5:2] of the 6-bit sum are the arithmetic >>>2 truncated to 4 bits.
    function automatic logic [3:0] scale_sum(input logic [5:0] s);
        logic [5:0] t;
    `ifdef IFFT_ROUND_EN
        t = s + 6'd2;
    `else
        t = s;
    `endif
        return t[5:2];
    endfunction

    assign w_last = w_in_valid && !w_sof_in && (r_state == COLLECT) && (r_idx == 2'd3);

    // Butterfly sums using the incoming beat directly as X3.
    always_comb begin
        logic [5:0] a, b, c, d;
        a    = sext(r_x0);
        b    = sext(r_x1);
        c    = sext(r_x2);
        d    = sext(w_bin_in);
        w_y0 = scale_sum(a + b + c + d);
        w_y1 = scale_sum(a + b - c - d);
        w_y2 = scale_sum(a - b + c - d);
        w_y3 = scale_sum(a - b - c + d);
    end

    // Frame collection FSM and registered emission pipeline.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state    <= HUNT;
            r_idx      <= 2'd0;
            r_x0       <= 4'd0;
            r_x1       <= 4'd0;
            r_x2       <= 4'd0;
            r_y1       <= 4'd0;
            r_y2       <= 4'd0;
            r_y3       <= 4'd0;
            r_emit_cnt <= 2'd0;
            r_sample   <= 4'd0;
            r_sof      <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_in_valid) begin
                case (r_state)
                    HUNT: begin
                        if (w_sof_in) begin
                            r_x0    <= w_bin_in;
                            r_idx   <= 2'd1;
                            r_state <= COLLECT;
                        end else begin
                            r_idx   <= 2'd0;
                        end
                    end
                    COLLECT: begin
                        if (w_sof_in) begin
                            r_x0  <= w_bin_in;
                            r_idx <= 2'd1;
                            r_err <= 1'b1;
                        end else begin
                            case (r_idx)
                                2'd1: begin
                                    r_x1  <= w_bin_in;
                                    r_idx <= 2'd2;
                                end
                                2'd2: begin
                                    r_x2  <= w_bin_in;
                                    r_idx <= 2'd3;
                                end
                                default: begin
                                    r_idx   <= 2'd0;
                                    r_state <= HUNT;
                                end
                            endcase
                        end
                    end
                    default: begin
                        r_idx   <= 2'd0;
                        r_state <= HUNT;
                    end
                endcase
            end else begin
                r_idx <= r_idx;
            end

            // A new frame's y0 takes priority; spacing guarantees the buffer has drained.
            if (w_last) begin
                r_sample   <= w_y0;
                r_sof      <= 1'b1;
                r_valid    <= 1'b1;
                r_y1       <= w_y1;
                r_y2       <= w_y2;
                r_y3       <= w_y3;
                r_emit_cnt <= 2'd3;
            end else if (r_emit_cnt != 2'd0) begin
                r_sample   <= r_y1;
                r_y1       <= r_y2;
                r_y2       <= r_y3;
                r_sof      <= 1'b0;
                r_valid    <= 1'b1;
                r_emit_cnt <= r_emit_cnt - 2'd1;
            end else begin
                r_sof   <= 1'b0;
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tiny_ifft.sv
// Self-checking bench for tiny_ifft: transaction-level reference model plus directed literal checks.
module tb_tiny_ifft;
    logic       clk = 1'b0;
    logic       t_rst = 1'b1;
    logic       t_sof = 1'b0;
    logic       t_vld = 1'b0;
    logic [3:0] t_bin = 4'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_checks = 0;
    int n_pass   = 0;

    assign io_in = {t_bin, t_vld, t_sof, t_rst, clk};

    tiny_ifft dut (.io_in(io_in), .io_out(io_out));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: frame list, pending output queue, sticky error.
    int         m_bins[$];
    logic [3:0] m_qval[$];
    bit         m_qsof[$];
    bit         m_err   = 1'b0;
    bit         armed   = 1'b0;
    logic [3:0] m_smp   = 4'd0;
    bit         m_vld   = 1'b0;
    bit         m_sof   = 1'b0;

    function automatic int sx(input logic [3:0] b);
        return b[3] ? int'(b) - 16 : int'(b);
    endfunction

    function automatic logic [3:0] scl(input int s);
        int t;
    `ifdef IFFT_ROUND_EN
        t = (s + 2) >>> 2;
    `else
        t = s >>> 2;
    `endif
        return t[3:0];
    endfunction

    function automatic int sgn(input int k, input int n);
        int tab [4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, 1, -1}, '{1, -1, -1, 1}};
        return tab[k][n];
    endfunction

    always @(posedge clk) begin
        if (t_rst) begin
            m_bins.delete(); m_qval.delete(); m_qsof.delete();
            m_err = 1'b0; m_smp = 4'd0; m_vld = 1'b0; m_sof = 1'b0;
            armed = 1'b1;
        end else begin
            if (t_vld) begin
                if (t_sof) begin
                    if (m_bins.size() > 0) m_err = 1'b1;
                    m_bins.delete();
                    m_bins.push_back(sx(t_bin));
                end else if (m_bins.size() > 0) begin
                    m_bins.push_back(sx(t_bin));
                    if (m_bins.size() == 4) begin
                        for (int k = 0; k < 4; k++) begin
                            int s;
                            s = 0;
                            for (int n = 0; n < 4; n++) s += sgn(k, n) * m_bins[n];
                            m_qval.push_back(scl(s));
                            m_qsof.push_back(k == 0);
                        end
                        m_bins.delete();
                    end
                end
            end
            if (m_qval.size() > 0) begin
                m_smp = m_qval.pop_front(); m_sof = m_qsof.pop_front(); m_vld = 1'b1;
            end else begin
                m_sof = 1'b0; m_vld = 1'b0;
            end
        end
        #1;
        if (armed) chk("cycle", io_out, {m_smp, 1'b0, m_err, m_vld, m_sof});
    end

    task automatic beat(input bit r, input bit s, input bit v, input logic [3:0] b);
        @(negedge clk);
        t_rst = r; t_sof = s; t_vld = v; t_bin = b;
        @(posedge clk);
        #2;
    endtask

    initial begin
        beat(1'b1, 1'b0, 1'b0, 4'd0);
        beat(1'b1, 1'b0, 1'b0, 4'd0);
        chk("reset", io_out, 8'h00);

        // X=1,1,1,1 -> y=1,0,0,0
        beat(1'b0, 1'b1, 1'b1, 4'd1);
        beat(1'b0, 1'b0, 1'b1, 4'd1);
        beat(1'b0, 1'b0, 1'b1, 4'd1);
        beat(1'b0, 1'b0, 1'b1, 4'd1);
        chk("ones_y0", io_out, 8'h13);
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 1'b0, 1'b0, 4'd0);
            chk("ones_yk", io_out, 8'h02);
        end
        beat(1'b0, 1'b0, 1'b0, 4'd0);
        chk("ones_idle", io_out, 8'h00);

        // back-to-back 4,0,0,0 then -4,0,0,0
        beat(1'b0, 1'b1, 1'b1, 4'd4);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        chk("b2b_a_y0", io_out, 8'h13);
        beat(1'b0, 1'b1, 1'b1, 4'hC);
        chk("b2b_a_y1", io_out, 8'h12);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        chk("b2b_a_y3", io_out, 8'h12);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        chk("b2b_b_y0", io_out, 8'hF3);
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 1'b0, 1'b0, 4'd0);
            chk("b2b_b_yk", io_out, 8'hF2);
        end
        beat(1'b0, 1'b0, 1'b0, 4'd0);
        chk("b2b_hold", io_out, 8'hF0);

        // gaps of 2 idle cycles between beats
        for (int i = 0; i < 4; i++) begin
            beat(1'b0, i == 0, 1'b1, 4'd1);
            if (i < 3) begin
                beat(1'b0, 1'b0, 1'b0, 4'd0);
                beat(1'b0, 1'b0, 1'b0, 4'd0);
            end
        end
        chk("gap_y0", io_out, 8'h13);
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b0, 1'b0, 4'd0);

        // sof on third beat -> sync_err, only restarted frame emitted
        beat(1'b0, 1'b1, 1'b1, 4'd1);
        beat(1'b0, 1'b0, 1'b1, 4'd1);
        beat(1'b0, 1'b1, 1'b1, 4'd1);
        chk("sync_err_set", io_out, 8'h04);
        beat(1'b0, 1'b0, 1'b1, 4'd1);
        beat(1'b0, 1'b0, 1'b1, 4'd1);
        beat(1'b0, 1'b0, 1'b1, 4'd1);
        chk("sync_y0", io_out, 8'h17);
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b0, 1'b0, 4'd0);
        chk("sync_sticky", io_out, 8'h04);
        beat(1'b1, 1'b0, 1'b0, 4'd0);
        chk("sync_reset", io_out, 8'h00);

        // reset during y1
        beat(1'b0, 1'b1, 1'b1, 4'd4);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        beat(1'b0, 1'b0, 1'b0, 4'd0);
        chk("rst_mid_y1", io_out, 8'h12);
        beat(1'b1, 1'b0, 1'b0, 4'd0);
        chk("rst_mid_clr", io_out, 8'h00);
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 1'b0, 1'b0, 4'd0);
            chk("rst_mid_quiet", io_out, 8'h00);
        end

        // X=2,0,0,0 exposes the scaling mode
        beat(1'b0, 1'b1, 1'b1, 4'd2);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
        beat(1'b0, 1'b0, 1'b1, 4'd0);
    `ifdef IFFT_ROUND_EN
        chk("two_y0", io_out, 8'h13);
    `else
        chk("two_y0", io_out, 8'h03);
    `endif
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b0, 1'b0, 4'd0);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            bit v;
            v = ($urandom_range(0, 9) < 7);
            beat($urandom_range(0, 199) == 0, v && ($urandom_range(0, 3) == 0), v, 4'($urandom));
        end
        beat(1'b0, 1'b0, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
